// File: rtl/loa_err_char_ctrl_if.sv
// Bus between the error-characterisation sequencer and its environment:
// run control, the adder-under-test operand/result lines and the accumulated statistics.
interface loa_err_char_ctrl_if #(
  parameter int N     = 16,
  parameter int CNT_W = 24
);
  logic               start;
  logic               abort;
  logic [CNT_W-1:0]   num_samples;
  logic [31:0]        seed_a;
  logic [31:0]        seed_b;
  logic [N-1:0]       add_a;
  logic [N-1:0]       add_b;
  logic [N-1:0]       add_sum;
  logic               add_co;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   err_count;
  logic [CNT_W+N:0]   sum_ed;
  logic [N:0]         max_ed;

  modport slave (
    input  start, abort, num_samples, seed_a, seed_b, add_sum, add_co,
    output add_a, add_b, busy, done, err_count, sum_ed, max_ed
  );

  modport master (
    output start, abort, num_samples, seed_a, seed_b, add_sum, add_co,
    input  add_a, add_b, busy, done, err_count, sum_ed, max_ed
  );
endinterface

// File: rtl/loa_err_char_ctrl.sv
// Error-characterisation sequencer: drives LFSR operand pairs into an external approximate
// adder, compares against the exact sum and accumulates error count, total and max distance.
module loa_err_char_ctrl #(
  parameter int N     = 16,
  parameter int CNT_W = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  loa_err_char_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_DRIVE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [31:0] LFSR_MASK = 32'h80200003;

  function automatic logic [31:0] f_lfsr_step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_MASK : 32'h0);
  endfunction

  function automatic logic [31:0] f_fix_seed(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  function automatic logic [N:0] f_abs_ed(input logic [N:0] x, input logic [N:0] y);
    logic signed [N+1:0] d;
    d = $signed({1'b0, x}) - $signed({1'b0, y});
    if (d < 0) d = -d;
    return d[N:0];
  endfunction

  state_t               r_state;
  logic [CNT_W-1:0]     r_num;
  logic [CNT_W-1:0]     r_remaining;
  logic [31:0]          r_seed_a;
  logic [31:0]          r_seed_b;
  logic [31:0]          r_lfsr_a;
  logic [31:0]          r_lfsr_b;
  logic [N-1:0]         r_add_a;
  logic [N-1:0]         r_add_b;
  logic                 r_busy;
  logic                 r_done;
  logic [CNT_W-1:0]     r_err_count;
  logic [CNT_W+N:0]     r_sum_ed;
  logic [N:0]           r_max_ed;

  logic [31:0]          w_seed_a;
  logic [31:0]          w_seed_b;
  logic [31:0]          w_lfsr_a_nxt;
  logic [31:0]          w_lfsr_b_nxt;
  logic [N:0]           w_exact;
  logic [N:0]           w_approx;
  logic [N:0]           w_ed;

  assign w_seed_a     = f_fix_seed(r_seed_a);
  assign w_seed_b     = f_fix_seed(r_seed_b);
  assign w_lfsr_a_nxt = f_lfsr_step(r_lfsr_a);
  assign w_lfsr_b_nxt = f_lfsr_step(r_lfsr_b);

  // The adder result is a combinational function of the registered operands.
  assign w_exact  = {1'b0, r_add_a} + {1'b0, r_add_b};
  assign w_approx = {bus.add_co, bus.add_sum};
  assign w_ed     = f_abs_ed(w_approx, w_exact);

  assign bus.add_a     = r_add_a;
  assign bus.add_b     = r_add_b;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err_count = r_err_count;
  assign bus.sum_ed    = r_sum_ed;
  assign bus.max_ed    = r_max_ed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_num       <= '0;
      r_remaining <= '0;
      r_seed_a    <= '0;
      r_seed_b    <= '0;
      r_lfsr_a    <= 32'h1;
      r_lfsr_b    <= 32'h1;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err_count <= '0;
      r_sum_ed    <= '0;
      r_max_ed    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_num    <= bus.num_samples;
            r_seed_a <= bus.seed_a;
            r_seed_b <= bus.seed_b;
            r_busy   <= 1'b1;
            r_state  <= S_SEED;
          end
        end
        S_SEED: begin
          if (bus.abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_lfsr_a    <= w_seed_a;
            r_lfsr_b    <= w_seed_b;
            r_err_count <= '0;
            r_sum_ed    <= '0;
            r_max_ed    <= '0;
            r_remaining <= r_num;
            if (r_num == '0) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_add_a <= w_seed_a[N-1:0];
              r_add_b <= w_seed_b[N-1:0];
              r_state <= S_DRIVE;
            end
          end
        end
        S_DRIVE: begin
          if (bus.abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          // Abort wins over the accumulate so a cancelled sample never counts.
          if (bus.abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            if (w_ed != '0) r_err_count <= r_err_count + CNT_W'(1);
            r_sum_ed    <= r_sum_ed + {{CNT_W{1'b0}}, w_ed};
            if (w_ed > r_max_ed) r_max_ed <= w_ed;
            r_lfsr_a    <= w_lfsr_a_nxt;
            r_lfsr_b    <= w_lfsr_b_nxt;
            r_remaining <= r_remaining - CNT_W'(1);
            if (r_remaining == CNT_W'(1)) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_add_a <= w_lfsr_a_nxt[N-1:0];
              r_add_b <= w_lfsr_b_nxt[N-1:0];
              r_state <= S_DRIVE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_loa_err_char_ctrl.sv
// Scoreboard bench: a driver issues runs and queues the results predicted by a plain
// arithmetic model; a monitor compares them whenever done pulses.
module tb_loa_err_char_ctrl;
  localparam int N     = 16;
  localparam int CNT_W = 24;

  typedef struct {
    longint err;
    longint sum;
    longint max;
    longint done_cyc;
  } exp_t;

  logic   clk;
  logic   rst;
  int     mode;
  longint cyc;
  int     n_checks;
  int     n_err;
  exp_t   sb_q[$];
  logic [16:0] stub_r;

  loa_err_char_ctrl_if #(.N(N), .CNT_W(CNT_W)) bus ();

  loa_err_char_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  // Adder-under-test models: 0 exact, 1 exact+1, 2 off by 16, 3 LOA with K=8.
  function automatic logic [16:0] approx(input int m, input logic [15:0] a, input logic [15:0] b);
    int e, r, lo, hi;
    e = int'(a) + int'(b);
    case (m)
      0: r = e;
      1: r = e + 1;
      2: r = (e >= 16) ? e - 16 : e + 16;
      default: begin
        lo = int'(a[7:0] | b[7:0]);
        hi = int'(a[15:8]) + int'(b[15:8]) + int'(a[7] & b[7]);
        r  = hi * 256 + lo;
      end
    endcase
    return 17'(r);
  endfunction

  assign stub_r      = approx(mode, bus.add_a, bus.add_b);
  assign bus.add_co  = stub_r[16];
  assign bus.add_sum = stub_r[15:0];

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h80200003 : 32'h0);
  endfunction

  // Statistics of a whole run, computed sample by sample from the operand sequences.
  function automatic void model(input int m, input int n, input logic [31:0] sa, input logic [31:0] sb,
                                output longint err, output longint sum, output longint mx);
    logic [31:0] la, lb;
    longint ex, ap, ed;
    la = (sa == 0) ? 32'h1 : sa;
    lb = (sb == 0) ? 32'h1 : sb;
    err = 0; sum = 0; mx = 0;
    for (int k = 0; k < n; k++) begin
      ex = longint'(la[15:0]) + longint'(lb[15:0]);
      ap = longint'(approx(m, la[15:0], lb[15:0]));
      ed = (ap > ex) ? ap - ex : ex - ap;
      if (ed != 0) err++;
      sum += ed;
      if (ed > mx) mx = ed;
      la = lfsr_step(la);
      lb = lfsr_step(lb);
    end
  endfunction

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("err_count", longint'(bus.err_count), e.err);
        check("sum_ed",    longint'(bus.sum_ed),    e.sum);
        check("max_ed",    longint'(bus.max_ed),    e.max);
        check("done_cycle", cyc, e.done_cyc);
      end
    end
  end

  task automatic issue_start(input int m, input int n, input logic [31:0] sa, input logic [31:0] sb,
                             output longint s);
    @(negedge clk);
    mode            = m;
    bus.num_samples = CNT_W'(n);
    bus.seed_a      = sa;
    bus.seed_b      = sb;
    bus.start       = 1'b1;
    @(posedge clk);
    #1;
    s         = cyc;
    bus.start = 1'b0;
  endtask

  task automatic run(input int m, input int n, input logic [31:0] sa, input logic [31:0] sb);
    longint s;
    exp_t   e;
    logic [31:0] fa, fb;
    issue_start(m, n, sa, sb, s);
    model(m, n, sa, sb, e.err, e.sum, e.max);
    e.done_cyc = s + 1 + 2 * n;
    sb_q.push_back(e);
    check("busy_in_seed", longint'(bus.busy), 1);
    bus.num_samples = CNT_W'($urandom);
    bus.seed_a      = $urandom;
    bus.seed_b      = $urandom;
    @(posedge clk);
    #1;
    if (n == 0) begin
      check("busy_after_seed", longint'(bus.busy), 0);
      check("done_after_seed", longint'(bus.done), 1);
    end else begin
      fa = (sa == 0) ? 32'h1 : sa;
      fb = (sb == 0) ? 32'h1 : sb;
      check("first_add_a", longint'(bus.add_a), longint'(fa[15:0]));
      check("first_add_b", longint'(bus.add_b), longint'(fb[15:0]));
    end
    if (n >= 3) begin
      @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
    end
    for (int i = 0; i < 2 * n + 40 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      check("done_timeout", longint'(sb_q.size()), 0);
      sb_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    longint s;
    n_checks = 0;
    n_err    = 0;
    mode     = 0;
    rst      = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.num_samples = '0;
    bus.seed_a = '0;
    bus.seed_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",   longint'(bus.busy), 0);
    check("rst_done",   longint'(bus.done), 0);
    check("rst_add_a",  longint'(bus.add_a), 0);
    check("rst_add_b",  longint'(bus.add_b), 0);
    check("rst_err",    longint'(bus.err_count), 0);
    check("rst_sum",    longint'(bus.sum_ed), 0);
    check("rst_max",    longint'(bus.max_ed), 0);
    @(negedge clk);
    rst = 1'b0;

    run(0, 1000, 32'd1, 32'd2);
    run(1, 100, 32'd1, 32'd2);
    run(0, 0, 32'd7, 32'd9);
    run(2, 50, 32'd0, 32'd0);

    // Abort during the third CHECK, with a start pulse earlier in the run.
    issue_start(1, 10, 32'd5, 32'd6, s);
    bus.num_samples = CNT_W'(3);
    repeat (2) @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("busy_before_abort", longint'(bus.busy), 1);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    check("abort_busy", longint'(bus.busy), 0);
    check("abort_err",  longint'(bus.err_count), 2);
    check("abort_sum",  longint'(bus.sum_ed), 2);
    check("abort_max",  longint'(bus.max_ed), 1);
    repeat (30) @(posedge clk);
    #1;
    check("abort_hold_err", longint'(bus.err_count), 2);
    check("abort_idle_busy", longint'(bus.busy), 0);

    // Asynchronous reset between edges in the middle of a run.
    issue_start(1, 50, 32'd11, 32'd12, s);
    repeat (20) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_busy",  longint'(bus.busy), 0);
    check("arst_err",   longint'(bus.err_count), 0);
    check("arst_sum",   longint'(bus.sum_ed), 0);
    check("arst_max",   longint'(bus.max_ed), 0);
    check("arst_add_a", longint'(bus.add_a), 0);
    @(negedge clk);
    rst = 1'b0;
    run(1, 20, 32'd11, 32'd12);

    run(3, 5000, $urandom, $urandom);
    for (int r = 0; r < 8; r++)
      run(int'($urandom_range(0, 3)), int'($urandom_range(0, 200)), $urandom, $urandom);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
